// File: rtl/core_pkg.sv
`default_nettype none
// ============================================================================
// Module      : core_pkg
// Description : Shared types for the RV32 execute-stage hazard controller.
// Revision    : 1.0 - initial release
// ============================================================================
package core_pkg;

    localparam int REG_W = 5;
    localparam logic [REG_W-1:0] REG_ZERO = '0;

    typedef enum logic [1:0] {
        FWD_RF    = 2'b00,
        FWD_EXMEM = 2'b01,
        FWD_MEMWB = 2'b10
    } fwd_sel_e;

    typedef struct packed {
        logic [REG_W-1:0] rd;
        logic             regwrite;
        logic             memread;
    } shadow_stage_t;

    // x0 is hard-wired, so a producer targeting it never creates a dependency.
    function automatic logic raw_hazard(input logic [REG_W-1:0] rs,
                                        input logic             uses,
                                        input shadow_stage_t    st);
        return uses && st.regwrite && (st.rd != REG_ZERO) && (rs == st.rd);
    endfunction

endpackage
`default_nettype wire

// File: rtl/sat_counter.sv
`default_nettype none
// ============================================================================
// Module      : sat_counter
// Description : Up-counter that sticks at all-ones instead of wrapping.
// Revision    : 1.0 - initial release
// ============================================================================
module sat_counter #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             clear,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    logic [CNT_W-1:0] r_cnt_q;
    logic [CNT_W-1:0] w_cnt_d;

    always_comb begin
        w_cnt_d = r_cnt_q;
        if (inc && (r_cnt_q != '1)) begin
            w_cnt_d = r_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (clear) begin
            r_cnt_q <= '0;
        end else begin
            r_cnt_q <= w_cnt_d;
        end
    end

    assign count = r_cnt_q;

endmodule
`default_nettype wire

// File: rtl/ex_hazard_unit.sv
`default_nettype none
// ============================================================================
// Module      : ex_hazard_unit
// Description : Forwarding, load-use stall, branch flush and memory-wait freeze
//               control for the EX stage of the 5-stage RV32 pipeline.
// Revision    : 1.0 - initial release
// ============================================================================
module ex_hazard_unit #(
    parameter int CNT_W    = 32,
    parameter int XLEN_REG = 5
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                id_valid,
    input  logic [XLEN_REG-1:0] id_rs1,
    input  logic [XLEN_REG-1:0] id_rs2,
    input  logic                id_uses_rs1,
    input  logic                id_uses_rs2,
    input  logic [XLEN_REG-1:0] id_rd,
    input  logic                id_regwrite,
    input  logic                id_memread,
    input  logic                ex_branch_taken,
    input  logic                mem_stall,
    output logic                stall_if,
    output logic                stall_id,
    output logic                stall_ex,
    output logic                flush_id,
    output logic                flush_ex,
    output logic [1:0]          fwd_a,
    output logic [1:0]          fwd_b,
    output logic [CNT_W-1:0]    perf_stall_cycles,
    output logic [CNT_W-1:0]    perf_flush_count
);

    import core_pkg::*;

    shadow_stage_t r_ex_q, r_mem_q, r_wb_q;
    shadow_stage_t w_ex_d, w_mem_d, w_wb_d;
    shadow_stage_t w_id_stage;
    fwd_sel_e      r_fwd_a_q, r_fwd_b_q;
    fwd_sel_e      w_fwd_a_d, w_fwd_b_d;

    logic w_rs1_ex, w_rs2_ex, w_rs1_mem, w_rs2_mem;
    logic w_load_use;
    logic w_stall_if, w_stall_id, w_stall_ex, w_flush_id, w_flush_ex;

    always_comb begin
        w_id_stage = '0;
        if (id_valid) begin
            w_id_stage.rd       = id_rd;
            w_id_stage.regwrite = id_regwrite;
            w_id_stage.memread  = id_memread;
        end
        w_rs1_ex   = raw_hazard(id_rs1, id_uses_rs1, r_ex_q);
        w_rs2_ex   = raw_hazard(id_rs2, id_uses_rs2, r_ex_q);
        w_rs1_mem  = raw_hazard(id_rs1, id_uses_rs1, r_mem_q);
        w_rs2_mem  = raw_hazard(id_rs2, id_uses_rs2, r_mem_q);
        w_load_use = id_valid && r_ex_q.memread && (w_rs1_ex || w_rs2_ex);
    end

    // Priority: reset, memory freeze, taken branch, then load-use.
    always_comb begin
        w_stall_if = 1'b0;
        w_stall_id = 1'b0;
        w_stall_ex = 1'b0;
        w_flush_id = 1'b0;
        w_flush_ex = 1'b0;
        if (reset) begin
            w_stall_if = 1'b0;
        end else if (mem_stall) begin
            w_stall_if = 1'b1;
            w_stall_id = 1'b1;
            w_stall_ex = 1'b1;
        end else if (ex_branch_taken) begin
            w_flush_id = 1'b1;
            w_flush_ex = 1'b1;
        end else if (w_load_use) begin
            w_stall_if = 1'b1;
            w_stall_id = 1'b1;
            w_flush_ex = 1'b1;
        end
    end

    always_comb begin
        w_ex_d    = r_ex_q;
        w_mem_d   = r_mem_q;
        w_wb_d    = r_wb_q;
        w_fwd_a_d = r_fwd_a_q;
        w_fwd_b_d = r_fwd_b_q;
        if (!mem_stall) begin
            w_wb_d    = r_mem_q;
            w_mem_d   = r_ex_q;
            w_ex_d    = w_flush_ex ? shadow_stage_t'('0) : w_id_stage;
            w_fwd_a_d = FWD_RF;
            w_fwd_b_d = FWD_RF;
            if (!w_flush_ex && id_valid) begin
                if (w_rs1_ex)       w_fwd_a_d = FWD_EXMEM;
                else if (w_rs1_mem) w_fwd_a_d = FWD_MEMWB;
                if (w_rs2_ex)       w_fwd_b_d = FWD_EXMEM;
                else if (w_rs2_mem) w_fwd_b_d = FWD_MEMWB;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_ex_q    <= '0;
            r_mem_q   <= '0;
            r_wb_q    <= '0;
            r_fwd_a_q <= FWD_RF;
            r_fwd_b_q <= FWD_RF;
        end else begin
            r_ex_q    <= w_ex_d;
            r_mem_q   <= w_mem_d;
            r_wb_q    <= w_wb_d;
            r_fwd_a_q <= w_fwd_a_d;
            r_fwd_b_q <= w_fwd_b_d;
        end
    end

    // WB shadow is kept for debug visibility; the write-through regfile means
    // no consumer needs it, nor the MEM-stage load flag.
    logic w_unused;
    assign w_unused = ^{r_wb_q, r_mem_q.memread};

    sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .clear (reset),
        .inc   (w_stall_id),
        .count (perf_stall_cycles)
    );

    sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .clear (reset),
        .inc   (w_flush_id),
        .count (perf_flush_count)
    );

    assign stall_if = w_stall_if;
    assign stall_id = w_stall_id;
    assign stall_ex = w_stall_ex;
    assign flush_id = w_flush_id;
    assign flush_ex = w_flush_ex;
    assign fwd_a    = r_fwd_a_q;
    assign fwd_b    = r_fwd_b_q;

endmodule
`default_nettype wire

// File: tb/tb_ex_hazard_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_ex_hazard_unit
// Description : Directed vector table plus randomized traffic against a
//               behavioural in-flight-instruction model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ex_hazard_unit;

    localparam int CNT_W = 32;

    logic             clk = 1'b0;
    logic             reset;
    logic             id_valid;
    logic [4:0]       id_rs1, id_rs2, id_rd;
    logic             id_uses_rs1, id_uses_rs2, id_regwrite, id_memread;
    logic             ex_branch_taken, mem_stall;
    logic             stall_if, stall_id, stall_ex, flush_id, flush_ex;
    logic [1:0]       fwd_a, fwd_b;
    logic [CNT_W-1:0] perf_stall_cycles, perf_flush_count;

    always #5 clk = ~clk;

    ex_hazard_unit #(.CNT_W(CNT_W), .XLEN_REG(5)) dut (
        .clk               (clk),
        .reset             (reset),
        .id_valid          (id_valid),
        .id_rs1            (id_rs1),
        .id_rs2            (id_rs2),
        .id_uses_rs1       (id_uses_rs1),
        .id_uses_rs2       (id_uses_rs2),
        .id_rd             (id_rd),
        .id_regwrite       (id_regwrite),
        .id_memread        (id_memread),
        .ex_branch_taken   (ex_branch_taken),
        .mem_stall         (mem_stall),
        .stall_if          (stall_if),
        .stall_id          (stall_id),
        .stall_ex          (stall_ex),
        .flush_id          (flush_id),
        .flush_ex          (flush_ex),
        .fwd_a             (fwd_a),
        .fwd_b             (fwd_b),
        .perf_stall_cycles (perf_stall_cycles),
        .perf_flush_count  (perf_flush_count)
    );

    typedef struct {
        string      name;
        logic       rst, vld;
        logic [4:0] rs1, rs2, rd;
        logic       u1, u2, wr, ld, br, ms;
        logic [4:0] exp_ctl;   // {stall_if, stall_id, stall_ex, flush_id, flush_ex}
        logic [1:0] exp_fa, exp_fb;
    } vec_t;

    vec_t tbl[$];
    int   checks = 0;
    int   errors = 0;

    // In-flight instructions after ID: index 0 = EX, 1 = MEM, 2 = WB.
    logic [4:0]       m_rd[3];
    logic             m_wr[3], m_ld[3];
    logic [1:0]       m_fa, m_fb;
    logic [CNT_W-1:0] m_stall, m_flush;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit depends_on(int k, logic [4:0] rs, logic uses);
        return uses && m_wr[k] && (m_rd[k] != 5'd0) && (m_rd[k] == rs);
    endfunction

    function automatic logic [1:0] nearest_producer(logic [4:0] rs, logic uses);
        for (int k = 0; k < 2; k++) begin
            if (depends_on(k, rs, uses)) return 2'(k + 1);
        end
        return 2'd0;
    endfunction

    function automatic logic [4:0] model_ctl();
        bit lu;
        lu = id_valid && m_ld[0] &&
             (depends_on(0, id_rs1, id_uses_rs1) || depends_on(0, id_rs2, id_uses_rs2));
        if (reset)           return 5'b00000;
        if (mem_stall)       return 5'b11100;
        if (ex_branch_taken) return 5'b00011;
        if (lu)              return 5'b11001;
        return 5'b00000;
    endfunction

    task automatic model_clear();
        for (int k = 0; k < 3; k++) begin
            m_rd[k] = 5'd0; m_wr[k] = 1'b0; m_ld[k] = 1'b0;
        end
        m_fa = 2'd0; m_fb = 2'd0; m_stall = '0; m_flush = '0;
    endtask

    task automatic addv(input string n, input logic rst, input logic vld,
                        input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                        input logic u1, input logic u2, input logic wr, input logic ld,
                        input logic br, input logic ms,
                        input logic [4:0] ctl, input logic [1:0] fa, input logic [1:0] fb);
        vec_t v;
        v.name = n; v.rst = rst; v.vld = vld; v.rs1 = rs1; v.rs2 = rs2; v.rd = rd;
        v.u1 = u1; v.u2 = u2; v.wr = wr; v.ld = ld; v.br = br; v.ms = ms;
        v.exp_ctl = ctl; v.exp_fa = fa; v.exp_fb = fb;
        tbl.push_back(v);
    endtask

    task automatic run_cycle(input vec_t v, input bit use_tbl);
        logic [4:0] ctl;
        logic [1:0] nfa, nfb;
        reset = v.rst; id_valid = v.vld; id_rs1 = v.rs1; id_rs2 = v.rs2; id_rd = v.rd;
        id_uses_rs1 = v.u1; id_uses_rs2 = v.u2; id_regwrite = v.wr; id_memread = v.ld;
        ex_branch_taken = v.br; mem_stall = v.ms;
        @(negedge clk);
        ctl = model_ctl();
        check({v.name, ":ctl_model"}, {stall_if, stall_id, stall_ex, flush_id, flush_ex}, ctl);
        check({v.name, ":fwd_model"}, {fwd_a, fwd_b}, {m_fa, m_fb});
        check({v.name, ":stall_cnt"}, perf_stall_cycles, m_stall);
        check({v.name, ":flush_cnt"}, perf_flush_count, m_flush);
        if (use_tbl) begin
            check({v.name, ":ctl_tbl"}, {stall_if, stall_id, stall_ex, flush_id, flush_ex}, v.exp_ctl);
            check({v.name, ":fwd_tbl"}, {fwd_a, fwd_b}, {v.exp_fa, v.exp_fb});
        end
        if (reset) begin
            model_clear();
        end else begin
            if (ctl[3] && m_stall != '1) m_stall++;
            if (ctl[1] && m_flush != '1) m_flush++;
            if (!mem_stall) begin
                nfa = (!ctl[0] && id_valid) ? nearest_producer(id_rs1, id_uses_rs1) : 2'd0;
                nfb = (!ctl[0] && id_valid) ? nearest_producer(id_rs2, id_uses_rs2) : 2'd0;
                for (int k = 2; k > 0; k--) begin
                    m_rd[k] = m_rd[k-1]; m_wr[k] = m_wr[k-1]; m_ld[k] = m_ld[k-1];
                end
                if (ctl[0] || !id_valid) begin
                    m_rd[0] = 5'd0; m_wr[0] = 1'b0; m_ld[0] = 1'b0;
                end else begin
                    m_rd[0] = id_rd; m_wr[0] = id_regwrite; m_ld[0] = id_memread;
                end
                m_fa = nfa; m_fb = nfb;
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        vec_t v;
        model_clear();
        //    name          rst vld rs1 rs2 rd  u1 u2 wr ld br ms ctl       fa fb
        addv("reset0",      1, 0,  0,  0,  0,  0, 0, 0, 0, 0, 0, 5'b00000, 0, 0);
        addv("reset1",      1, 0,  0,  0,  0,  0, 0, 0, 0, 0, 0, 5'b00000, 0, 0);
        addv("fwd_add",     0, 1,  1,  2,  5,  1, 1, 1, 0, 0, 0, 5'b00000, 0, 0);
        addv("fwd_sub",     0, 1,  5,  3,  6,  1, 1, 1, 0, 0, 0, 5'b00000, 0, 0);
        addv("fwd_sub_ex",  0, 0,  0,  0,  0,  0, 0, 0, 0, 0, 0, 5'b00000, 1, 0);
        addv("lu_lw",       0, 1,  1,  0,  7,  1, 0, 1, 1, 0, 0, 5'b00000, 0, 0);
        addv("lu_stall",    0, 1,  7,  7,  8,  1, 1, 1, 0, 0, 0, 5'b11001, 0, 0);
        addv("lu_held",     0, 1,  7,  7,  8,  1, 1, 1, 0, 0, 0, 5'b00000, 0, 0);
        addv("lu_ex",       0, 0,  0,  0,  0,  0, 0, 0, 0, 0, 0, 5'b00000, 2, 2);
        addv("x0_addi",     0, 1,  1,  0,  0,  1, 0, 1, 0, 0, 0, 5'b00000, 0, 0);
        addv("x0_add",      0, 1,  0,  0,  9,  1, 1, 1, 0, 0, 0, 5'b00000, 0, 0);
        addv("x0_ex",       0, 0,  0,  0,  0,  0, 0, 0, 0, 0, 0, 5'b00000, 0, 0);
        addv("br_lw",       0, 1,  1,  0,  7,  1, 0, 1, 1, 0, 0, 5'b00000, 0, 0);
        addv("br_lu",       0, 1,  7,  7,  8,  1, 1, 1, 0, 1, 0, 5'b00011, 0, 0);
        addv("br_after",    0, 0,  0,  0,  0,  0, 0, 0, 0, 0, 0, 5'b00000, 0, 0);
        addv("ms_br1",      0, 0,  0,  0,  0,  0, 0, 0, 0, 1, 1, 5'b11100, 0, 0);
        addv("ms_br2",      0, 0,  0,  0,  0,  0, 0, 0, 0, 1, 1, 5'b11100, 0, 0);
        addv("ms_br3",      0, 0,  0,  0,  0,  0, 0, 0, 0, 1, 1, 5'b11100, 0, 0);
        addv("ms_br_rel",   0, 0,  0,  0,  0,  0, 0, 0, 0, 1, 0, 5'b00011, 0, 0);
        addv("hold_add",    0, 1,  1,  2,  5,  1, 1, 1, 0, 0, 0, 5'b00000, 0, 0);
        addv("hold_sub",    0, 1,  5,  3,  6,  1, 1, 1, 0, 0, 0, 5'b00000, 0, 0);
        addv("hold_ms1",    0, 1,  6,  0, 10,  1, 0, 1, 0, 0, 1, 5'b11100, 1, 0);
        addv("hold_ms2",    0, 1,  6,  0, 10,  1, 0, 1, 0, 0, 1, 5'b11100, 1, 0);
        addv("hold_rel",    0, 1,  6,  0, 10,  1, 0, 1, 0, 0, 0, 5'b00000, 1, 0);
        addv("hold_ex",     0, 0,  0,  0,  0,  0, 0, 0, 0, 0, 0, 5'b00000, 1, 0);
        addv("pend_lw",     0, 1,  1,  0,  7,  1, 0, 1, 1, 0, 0, 5'b00000, 0, 0);
        addv("pend_ms",     0, 1,  7,  7,  8,  1, 1, 1, 0, 0, 1, 5'b11100, 0, 0);
        addv("pend_rel",    0, 1,  7,  7,  8,  1, 1, 1, 0, 0, 0, 5'b11001, 0, 0);
        addv("pend_held",   0, 1,  7,  7,  8,  1, 1, 1, 0, 0, 0, 5'b00000, 0, 0);
        addv("pend_ex",     0, 0,  0,  0,  0,  0, 0, 0, 0, 0, 0, 5'b00000, 2, 2);
        addv("rst_lw",      0, 1,  1,  0,  7,  1, 0, 1, 1, 0, 0, 5'b00000, 0, 0);
        addv("rst_lu",      0, 1,  7,  7,  8,  1, 1, 1, 0, 0, 0, 5'b11001, 0, 0);
        addv("rst_mid",     1, 1,  7,  7,  8,  1, 1, 1, 0, 1, 1, 5'b00000, 0, 0);
        addv("rst_after",   0, 0,  0,  0,  0,  0, 0, 0, 0, 0, 0, 5'b00000, 0, 0);

        foreach (tbl[i]) run_cycle(tbl[i], 1'b1);

        // Flush counter pinned at all-ones must not wrap on a further flush.
        force dut.u_flush_cnt.r_cnt_q = '1;
        #1;
        release dut.u_flush_cnt.r_cnt_q;
        m_flush = '1;
        v = tbl[tbl.size()-1];
        v.name = "sat_br"; v.br = 1'b1;
        run_cycle(v, 1'b0);
        v.name = "sat_idle"; v.br = 1'b0;
        run_cycle(v, 1'b0);
        check("sat_hold", perf_flush_count, {CNT_W{1'b1}});

        for (int n = 0; n < 3000; n++) begin
            v.name = "rand";
            v.rst = ($urandom_range(0, 199) == 0);
            v.vld = ($urandom_range(0, 4) != 0);
            v.rs1 = 5'($urandom_range(0, 3));
            v.rs2 = 5'($urandom_range(0, 3));
            v.rd  = 5'($urandom_range(0, 3));
            v.u1  = 1'($urandom_range(0, 1));
            v.u2  = 1'($urandom_range(0, 1));
            v.wr  = ($urandom_range(0, 3) != 0);
            v.ld  = ($urandom_range(0, 2) == 0);
            v.br  = ($urandom_range(0, 7) == 0);
            v.ms  = ($urandom_range(0, 5) == 0);
            run_cycle(v, 1'b0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/ex_hazard_unit.md
Name: ex_hazard_unit

Overview:
- Pipeline hazard controller that sequences the execute-stage ALU for the 5-stage RV32 core (IF/ID/EX/MEM/WB).
- Tracks destination-register shadow state for EX, MEM and WB.
- Produces registered ALU operand-forwarding selects, load-use stalls, taken-branch flushes and a global freeze on data-memory wait.
- Exports saturating performance counters for stall and flush events.

Parameters:
- CNT_W, 32, width of performance counters (saturating)
- XLEN_REG, 5, register-index width

Ports:
- clk  in  1  core clock
- reset  in  1  synchronous, active-high reset
- id_valid  in  1  ID holds a real instruction
- id_rs1  in  5  ID source register 1
- id_rs2  in  5  ID source register 2
- id_uses_rs1  in  1  ID instruction reads rs1
- id_uses_rs2  in  1  ID instruction reads rs2
- id_rd  in  5  ID destination register
- id_regwrite  in  1  ID instruction writes rd
- id_memread  in  1  ID instruction is a load
- ex_branch_taken  in  1  branch/jump resolved taken in EX (from ALU zero/neg + pcadder)
- mem_stall  in  1  data memory not ready; freeze whole pipe
- stall_if  out  1  hold PC
- stall_id  out  1  hold IF/ID register
- stall_ex  out  1  hold ID/EX, EX/MEM and MEM/WB registers (mem_stall only)
- flush_id  out  1  convert IF/ID contents to bubble
- flush_ex  out  1  load bubble into ID/EX
- fwd_a  out  2  ALU data1 source for instruction in EX: 00 regfile, 01 EX/MEM result, 10 MEM/WB result
- fwd_b  out  2  ALU op2 register-source select, same encoding
- perf_stall_cycles  out  CNT_W  cycles with load-use stall or mem_stall asserted
- perf_flush_count  out  CNT_W  number of taken-branch flushes

Behaviour:
- Reset (sync, active-high): all outputs 0; shadow ex/mem/wb rd=0, regwrite=0, memread=0; counters 0. Reset mid-stall or mid-flush drops the stall/flush on the next edge.
- Shadow pipe: on each edge without freeze, wb<=mem, mem<=ex, and ex<=ID fields (valid-gated). When a bubble is injected, ex<=0.
- Hazard rule: a match requires rd!=0, regwrite=1, uses_rsN=1, rsN==rd. x0 never forwards or stalls.
- Forwarding: computed combinationally in ID, registered into fwd_a/fwd_b as the instruction enters EX.
  - Match against shadow ex: fwd=01.
  - Else match against shadow mem: fwd=10.
  - Else fwd=00. Nearest producer wins.
  - The regfile is write-through, so a WB-vs-ID match needs no forwarding.
- Load-use (combinational): id_valid & ex_memread & hazard(ex_rd) -> stall_if=stall_id=1 and flush_ex=1 (bubble) for exactly 1 cycle.
  - In the next cycle the load is in MEM and the dependant gets fwd=10.
- Taken branch (combinational): ex_branch_taken -> flush_id=1 and flush_ex=1 for the cycle; IF redirected by the PC mux.
  - A branch has priority over load-use: stall_if/stall_id are forced 0 that cycle.
- mem_stall has highest priority:
  - stall_if=stall_id=stall_ex=1; flush_id/flush_ex forced 0.
  - Shadow state and fwd registers hold.
  - A pending ex_branch_taken or load-use is acted on in the first cycle after mem_stall drops, since EX state is frozen.
- Counters:
  - perf_stall_cycles +1 per cycle with load-use stall or mem_stall.
  - perf_flush_count +1 per cycle with a branch flush not masked by mem_stall.
  - Both saturate at all-ones, no wrap.
- Latency: stall/flush outputs are same-cycle combinational from shadow state plus inputs; fwd is 1-cycle registered.

Decomposition:
- Shared package (core_pkg): fwd_sel_e enum (FWD_RF=2'b00, FWD_EXMEM=2'b01, FWD_MEMWB=2'b10); shadow_stage_t struct {rd, regwrite, memread}; REG_ZERO constant.
- One natural sub-module: sat_counter (parameter CNT_W, inputs inc and clear), instantiated twice.

Test Plan:
- add x5,x1,x2 then sub x6,x5,x3 back-to-back -> sub enters EX with fwd_a=01, fwd_b=00; no stall.
- lw x7,0(x1) then add x8,x7,x7 -> 1 cycle stall_if=stall_id=flush_ex=1; add then in EX with fwd_a=fwd_b=10; perf_stall_cycles=1.
- addi x0,x1,5 then add x9,x0,x0 -> fwd_a=fwd_b=00, no stall (x0 rule).
- ex_branch_taken=1 in the same cycle as a load-use hazard in ID -> flush_id=flush_ex=1, stall_if=0; perf_flush_count=1, perf_stall_cycles=0.
- mem_stall=1 for 3 cycles with ex_branch_taken=1 -> stall_if/id/ex=1 and flush=0 for 3 cycles, flush on the 4th cycle; perf_stall_cycles=3.
- Preload perf_flush_count to all-ones via force, then branch flush -> value stays all-ones; reset asserted during a stall -> all outputs 0 next cycle.
